// File: rtl/mini_core_accel_pkg.sv
// Shared types and constants for the mini_core_accel front end.
// The loader uses these to decode core writes and to hold the
// 4x4 int8 operand images handed to systolic_array_ctrl.
package mini_core_accel_pkg;

   // Loader sequencing: collect operands, run the array, hold the result flag
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } t_loader_state;

   // Control addresses above the eight operand word slots
   localparam logic [3:0] LOADER_ADDR_GO    = 4'd8;
   localparam logic [3:0] LOADER_ADDR_CLEAR = 4'd9;

   // One full operand: 16 int8 lanes packed little-endian by word
   typedef logic [127:0] t_operand;

   // Every operand word slot has been written since the last CLEAR/reset
   localparam logic [7:0] LOADER_MASK_FULL = 8'hFF;

endpackage

// File: rtl/systolic_array_loader.sv
// Upstream feeder for systolic_array_ctrl. Gathers eight 32-bit core
// writes into the weight and activation operands, launches a run by
// holding start until the array answers with valid, and records
// completion, protocol errors and a watchdog timeout as sticky flags.
module systolic_array_loader
   import mini_core_accel_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int NUM_WORDS   = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [3:0]        wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   output t_operand          all_weights,
   output t_operand          all_activations,
   output logic              start,
   input  logic              valid,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              timeout
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYC);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

   t_loader_state      state;
   logic [7:0]         mask;
   logic [TIMER_W-1:0] timer;

   // Single sequencer: operand capture, run handshake, watchdog and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         mask            <= 8'h00;
         timer           <= '0;
         all_weights     <= '0;
         all_activations <= '0;
         start           <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         timeout         <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (wr_en) begin
                  if (!wr_addr[3]) begin
                     // Re-writing a slot in DONE leaves its mask bit set
                     for (int k = 0; k < NUM_WORDS; k++) begin
                        if (wr_addr[1:0] == k[1:0]) begin
                           if (wr_addr[2])
                              all_activations[k*WORD_W +: WORD_W] <= wr_data;
                           else
                              all_weights[k*WORD_W +: WORD_W] <= wr_data;
                        end
                     end
                     mask[wr_addr[2:0]] <= 1'b1;
                  end else if (wr_addr == LOADER_ADDR_GO) begin
                     if (mask == LOADER_MASK_FULL) begin
                        state <= RUN;
                        start <= 1'b1;
                        busy  <= 1'b1;
                        timer <= '0;
                     end else begin
                        err <= 1'b1;
                     end
                  end else if (wr_addr == LOADER_ADDR_CLEAR) begin
                     state   <= IDLE;
                     mask    <= 8'h00;
                     done    <= 1'b0;
                     err     <= 1'b0;
                     timeout <= 1'b0;
                  end
               end
            end

            RUN: begin
               // Operands are frozen while the array consumes them
               if (wr_en)
                  err <= 1'b1;
               if (valid) begin
                  state <= DONE;
                  start <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (timer == TIMER_LAST) begin
                  state   <= IDLE;
                  start   <= 1'b0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               start <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_array_loader.sv
// Directed bench for systolic_array_loader. Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away
// from the registering edge.
module tb_systolic_array_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_en;
   logic [3:0]   wr_addr;
   logic [31:0]  wr_data;
   logic [127:0] all_weights;
   logic [127:0] all_activations;
   logic         start;
   logic         valid;
   logic         busy;
   logic         done;
   logic         err;
   logic         timeout;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] EXP_W = 128'h0509040D_0803110C_0702100B_060F0A0E;
   localparam logic [127:0] EXP_A = 128'h0D0E090F_0A05100B_06010C07_02080304;

   always #5 clk = ~clk;

   systolic_array_loader #(
      .WORD_W      (32),
      .NUM_WORDS   (4),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .all_weights     (all_weights),
      .all_activations (all_activations),
      .start           (start),
      .valid           (valid),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .timeout         (timeout)
   );

   // One write cycle; returns on the falling edge after it was registered
   task automatic do_write(input logic [3:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
      wr_addr = 4'd0;
      wr_data = 32'd0;
   endtask

   task automatic load_all();
      do_write(4'd0, 32'h060F0A0E);
      do_write(4'd1, 32'h0702100B);
      do_write(4'd2, 32'h0803110C);
      do_write(4'd3, 32'h0509040D);
      do_write(4'd4, 32'h02080304);
      do_write(4'd5, 32'h06010C07);
      do_write(4'd6, 32'h0A05100B);
      do_write(4'd7, 32'h0D0E090F);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_valid();
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_cycles(3);
      rst = 1'b0;
      checks++;
      if ({start, busy, done, err, timeout} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want 00000", {start, busy, done, err, timeout});
      end
      checks++;
      if (all_weights !== 128'd0 || all_activations !== 128'd0) begin
         errors++;
         $display("[TB] FAIL reset_operands got w=%h a=%h want 0", all_weights, all_activations);
      end
   endtask

   task automatic test_load_and_run();
      load_all();
      checks++;
      if (all_weights !== EXP_W) begin
         errors++;
         $display("[TB] FAIL pack_weights got %h want %h", all_weights, EXP_W);
      end
      checks++;
      if (all_activations !== EXP_A) begin
         errors++;
         $display("[TB] FAIL pack_activations got %h want %h", all_activations, EXP_A);
      end
      do_write(4'd8, 32'd0);
      checks++;
      if (start !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL go_start got start=%b busy=%b want 1 1", start, busy);
      end
      idle_cycles(5);
      checks++;
      if (start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL start_held got %b want 1", start);
      end
      pulse_valid();
      checks++;
      if ({start, busy, done, err, timeout} !== 5'b00100) begin
         errors++;
         $display("[TB] FAIL run_done got %b want 00100", {start, busy, done, err, timeout});
      end
   endtask

   task automatic test_incomplete_go();
      do_write(4'd9, 32'd0);
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clear_flags got done=%b err=%b want 0 0", done, err);
      end
      checks++;
      if (all_weights !== EXP_W) begin
         errors++;
         $display("[TB] FAIL clear_keeps_operands got %h want %h", all_weights, EXP_W);
      end
      do_write(4'd0, 32'h11111111);
      do_write(4'd1, 32'h22222222);
      do_write(4'd2, 32'h33333333);
      do_write(4'd3, 32'h44444444);
      do_write(4'd8, 32'd0);
      idle_cycles(3);
      checks++;
      if (err !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL partial_go got err=%b start=%b busy=%b want 1 0 0", err, start, busy);
      end
      pulse_valid();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL valid_ignored_idle got done=%b want 0", done);
      end
      do_write(4'd9, 32'd0);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clear_err got %b want 0", err);
      end
      do_write(4'd8, 32'd0);
      checks++;
      if (err !== 1'b1 || start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL go_after_clear got err=%b start=%b want 1 0", err, start);
      end
      do_write(4'd9, 32'd0);
   endtask

   task automatic test_write_while_busy();
      load_all();
      do_write(4'd8, 32'd0);
      do_write(4'd2, 32'hFFFFFFFF);
      checks++;
      if (all_weights !== EXP_W) begin
         errors++;
         $display("[TB] FAIL busy_write_dropped got %h want %h", all_weights, EXP_W);
      end
      checks++;
      if (err !== 1'b1 || start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_write_err got err=%b start=%b want 1 1", err, start);
      end
      idle_cycles(2);
      pulse_valid();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_run_done got done=%b busy=%b start=%b want 1 0 0", done, busy, start);
      end
      do_write(4'd9, 32'd0);
   endtask

   task automatic test_timeout();
      int high_cycles;
      high_cycles = 0;
      load_all();
      do_write(4'd8, 32'd0);
      for (int i = 0; i < 200 && start === 1'b1; i++) begin
         high_cycles++;
         @(negedge clk);
      end
      checks++;
      if (high_cycles != 64) begin
         errors++;
         $display("[TB] FAIL timeout_len got %0d want 64", high_cycles);
      end
      checks++;
      if ({start, busy, done, err, timeout} !== 5'b00011) begin
         errors++;
         $display("[TB] FAIL timeout_flags got %b want 00011", {start, busy, done, err, timeout});
      end
      do_write(4'd9, 32'd0);
      checks++;
      if (timeout !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_clear got timeout=%b err=%b want 0 0", timeout, err);
      end
   endtask

   task automatic test_reset_mid_run();
      load_all();
      do_write(4'd8, 32'd0);
      idle_cycles(2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({start, busy, done, err, timeout} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL midrun_reset_flags got %b want 00000", {start, busy, done, err, timeout});
      end
      checks++;
      if (all_weights !== 128'd0 || all_activations !== 128'd0) begin
         errors++;
         $display("[TB] FAIL midrun_reset_operands got w=%h a=%h want 0", all_weights, all_activations);
      end
      do_write(4'd8, 32'd0);
      checks++;
      if (err !== 1'b1 || start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL go_after_reset got err=%b start=%b want 1 0", err, start);
      end
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = 4'd0;
      wr_data = 32'd0;
      valid   = 1'b0;
      @(negedge clk);
      test_reset();
      test_load_and_run();
      test_incomplete_go();
      test_write_while_busy();
      test_timeout();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_array_loader.md
Name: systolic_array_loader

Overview:
Upstream feeder for systolic_array_ctrl in mini_core_accel. Accepts 32-bit word writes from the mini_core side and assembles the 128-bit all_weights and all_activations operands (4x4 int8 each). Pulses the run handshake (start held until valid) and tracks completion, errors and a watchdog timeout. Bytes pass through unchanged; any skew or ordering is done by software.

Parameters:
WORD_W, 32, core write data width
NUM_WORDS, 4, words per operand (128 / WORD_W)
TIMEOUT_CYC, 64, cycles in RUN without valid before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  core write strobe, one write per cycle
wr_addr  in  4  0-3 weight word k, 4-7 activation word k, 8 GO, 9 CLEAR; 10-15 ignored
wr_data  in  32  write data (ignored for GO/CLEAR)
all_weights  out  128  to systolic_array_ctrl.all_weights
all_activations  out  128  to systolic_array_ctrl.all_activations
start  out  1  to systolic_array_ctrl.start
valid  in  1  from systolic_array_ctrl.valid
busy  out  1  high in RUN
done  out  1  sticky, set on valid in RUN
err  out  1  sticky: write while busy, GO with incomplete operands, or timeout
timeout  out  1  sticky, err cause is timeout

Behaviour:
- Reset (sync, rst=1 at posedge): operand regs=0, written mask=8'h00, state=IDLE, start=busy=done=err=timeout=0, timer=0. Reset mid-RUN aborts immediately; start drops at the next edge.
- Word packing: word k occupies bits [32k+31:32k] of its operand. addr 0-3 set mask bits 0-3; addr 4-7 set mask bits 4-7. Register update is visible on outputs 1 cycle after the write edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Operand writes accepted.
  - GO with mask==8'hFF -> RUN at next edge. start and busy go 1 in the same cycle RUN is entered; timer=0.
  - GO with mask incomplete -> err=1, stay IDLE.
- RUN:
  - start held 1, operand regs frozen.
  - Any wr_en (operand or GO) -> dropped, err=1. CLEAR is also dropped.
  - valid=1 -> DONE, start=0, busy=0, done=1 at that edge. Latency GO-edge to start=1 is 1 cycle.
  - Timer increments each cycle. When timer reaches TIMEOUT_CYC-1 with no valid -> IDLE, err=timeout=1, start=0. valid in that same cycle wins: DONE, no timeout.
- DONE:
  - Operand writes accepted; they clear their mask bit first and then set it, so mask stays as before (no change).
  - GO with mask==8'hFF -> RUN again (re-run with the same or updated operands); done stays set until CLEAR.
- CLEAR (any state except RUN): done=err=timeout=0, mask=0, state->IDLE; operand regs keep their values.
- CLEAR and an operand write cannot coincide (single port). valid outside RUN is ignored.

Decomposition:
- Into mini_core_accel_pkg:
  - typedef t_loader_state {IDLE, RUN, DONE}
  - localparams LOADER_ADDR_GO=4'd8, LOADER_ADDR_CLEAR=4'd9
  - t_operand (logic [127:0])
- No sub-module. The timeout counter is inline.

Test Plan:
- Reset then write weights words 0-3 = 32'h060F0A0E, 32'h0702100B, 32'h0803110C, 32'h0509040D, and activations words 4-7 = 32'h02080304, 32'h06010C07, 32'h0A05100B, 32'h0D0E090F. -> all_weights=128'h05_09_04_0D_08_03_11_0C_07_02_10_0B_06_0F_0A_0E and all_activations=128'h0D_0E_09_0F_0A_05_10_0B_06_01_0C_07_02_08_03_04. Then GO -> start=busy=1 next cycle.
- Above sequence connected to systolic_array_ctrl -> start stays high until valid; done=1, start=0 at the valid edge; err=0.
- GO after only weight words written -> err=1, start never asserts; CLEAR -> err=0, mask=0.
- In RUN write addr 2 data 32'hFFFFFFFF -> all_weights unchanged, err=1, run still completes with done=1.
- GO with valid tied 0, TIMEOUT_CYC=64 -> start high exactly 64 cycles, then err=timeout=1, busy=0, state IDLE.
- rst=1 for one cycle mid-RUN -> next cycle start=busy=done=err=0 and outputs=0; a following GO is rejected with err=1 (mask cleared).
